serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: N, 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 Port: a  input  N  first operand, unsigned or two's complement.
REQ-006 Port: b  input  N  second operand.
REQ-007 Port: a_ns  input  1  operation select; 1 = add (a+b), 0 = subtract (a-b).
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse; result/cout/ovf valid.
REQ-010 Port: result  output  N  sum or difference, modulo 2^N.
REQ-011 Port: cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).
REQ-012 Port: ovf  output  1  two's-complement overflow flag.

Function
REQ-013 The block SHALL compute one bit per clock using a single full adder/subtractor bit-slice, a carry flip-flop and operand/result shift registers.
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start=1.
- SHIFT -> DONE after the N-th bit.
- DONE -> IDLE unconditionally.
REQ-015 On the accepting edge in IDLE, the block SHALL capture a, b and a_ns, load carry = ~a_ns, and clear the bit counter.
REQ-016 While in SHIFT, each edge SHALL process bit i (LSB first): sum = a[i] ^ (b[i] ^ ~a_ns) ^ carry. The new carry SHALL be the majority function of those three inputs. The sum bit SHALL shift into the result register MSB, shifting right.
REQ-017 busy SHALL be 1 exactly in SHIFT, i.e. for N cycles after the accepting edge.
REQ-018 done SHALL be 1 only in DONE, i.e. in the cycle after the N-th SHIFT edge. Latency from the accepting edge to done is N+1 edges.
REQ-019 result, cout and ovf SHALL be valid while done=1. They SHALL hold their values until the next accepted start. During SHIFT, result is unchecked.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored. It is not queued.
REQ-021 a, b and a_ns changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-022 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE. Back-to-back period is N+2 cycles.
REQ-023 cout SHALL equal the carry out of bit N-1.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state IDLE and clear the following to 0: busy, done, result, cout, ovf, carry, the bit counter and the operand registers.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse. The first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-026 Macro SERIAL_ADDSUB_OVF_EN defined: ovf SHALL equal carry-into-bit-(N-1) XOR carry-out-of-bit-(N-1), registered with cout.
REQ-027 Macro SERIAL_ADDSUB_OVF_EN undefined: the ovf port SHALL still exist, tied constant 0, with no overflow logic synthesized.

Verification (N=8)
REQ-028 Add: a=0x05, b=0x03, a_ns=1, start pulse -> done 9 edges after the accepting edge; result=0x08, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-029 Add wrap: a=0xFF, b=0x01, a_ns=1 -> result=0x00, cout=1, ovf=0. Overflow case: a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1 with the macro, ovf=0 without.
REQ-030 Subtract: a=0x05, b=0x03, a_ns=0 -> result=0x02, cout=1. Borrow case: a=0x03, b=0x05 -> result=0xFE, cout=0, ovf=0.
REQ-031 Ignore and hold: pulse start again at the 3rd busy cycle with different operands -> the first result is unchanged and no extra done occurs. Change a/b during busy -> no effect.
REQ-032 Reset abort: assert rst_n=0 at the 4th busy cycle -> busy=0, done=0 and result=0 immediately, with no done pulse. A new start after release yields a correct result.
REQ-033 Exhaustive sweep: all 256x256 operand pairs for both a_ns values, with start held high -> every result/cout/ovf matches the reference model, with done spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, N+1 edges per operation.
// Define SERIAL_ADDSUB_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied 0.
module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         a_ns,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         ovf
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [N-1:0]       result_q, result_d;
    logic               ns_q, ns_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic b_eff;
    logic sum_bit;
    logic carry_nxt;

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (cnt_q == CNT_W'(N - 1));

    // Subtract is a + ~b + 1: b is inverted here and the +1 comes from the preloaded carry.
    assign b_eff     = b_q[0] ^ ~ns_q;
    assign sum_bit   = a_q[0] ^ b_eff ^ carry_q;
    assign carry_nxt = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        ns_d     = ns_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            ns_d    = a_ns;
            carry_d = ~a_ns;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            carry_d  = carry_nxt;
            cnt_d    = cnt_q + 1'b1;
            result_d = {sum_bit, result_q[N-1:1]};
            if (last_bit) begin
                cout_d = carry_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            ns_q     <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            ns_q     <= ns_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit carry_q is the carry into the sign bit, carry_nxt the carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == SHIFT && last_bit) begin
            ovf_d = carry_q ^ carry_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (N=8): directed vectors, ignore/hold, reset abort, back-to-back run.
module tb_serial_addsub;

    localparam int N = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a, b;
    logic         a_ns;
    logic         busy, done;
    logic [N-1:0] result;
    logic         cout, ovf;

    int total = 0;
    int bad   = 0;
    logic [N+1:0] sb[$];

    serial_addsub #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .a_ns(a_ns),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: plain 9-bit arithmetic and sign-bit overflow rule.
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ns);
        logic [N-1:0] yy;
        logic [N:0]   s;
        logic         v;
        yy = ns ? y : ~y;
        s  = {1'b0, x} + {1'b0, yy} + {{N{1'b0}}, ~ns};
        v  = (x[N-1] == yy[N-1]) && (s[N-1] != x[N-1]) && OVF_EN;
        return {s[N-1:0], s[N], v};
    endfunction

    task automatic monitor();
        logic [N+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e[N+1:2]));
                    chk("cout", 32'(cout), 32'(e[1]));
                    chk("ovf", 32'(ovf), 32'(e[0]));
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'(n), 32'(0));
    endtask

    // mode 1: re-pulse start at the 3rd busy cycle and scramble operands while busy.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic ns,
                          input logic [N-1:0] er, input logic ec, input logic ev, input int mode);
        int busy_n = 0;
        int done_at = 0;
        wait_idle();
        a = x; b = y; a_ns = ns; start = 1'b1;
        sb.push_back({er, ec, ev & OVF_EN});
        @(posedge clk);
        for (int i = 1; i <= N + 1; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (mode == 1 && i == 3) begin start = 1'b1; a = 8'h11; b = 8'h22; end
            if (mode == 1 && i == 4) start = 1'b0;
            if (mode == 1 && i == 5) begin a = 8'h99; b = 8'h77; a_ns = ~ns; end
            if (busy) busy_n++;
            if (done && done_at == 0) done_at = i;
        end
        chk("busy_cycles", 32'(busy_n), 32'(N));
        chk("done_latency", 32'(done_at), 32'(N + 1));
        repeat (2) @(negedge clk);
        chk("hold_result", 32'(result), 32'(er));
        chk("hold_cout", 32'(cout), 32'(ec));
    endtask

    initial begin
        logic [N+1:0] e;
        int cnt;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; a_ns = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        rst_n = 1'b1;

        //       a      b      ns    result cout ovf
        run_op(8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b1, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0, 0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'hAA, 8'h55, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
        run_op(8'h01, 8'h80, 1'b0, 8'h81, 1'b0, 1'b1, 0);
        run_op(8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0, 1);

        // Reset in the 4th busy cycle: outputs clear at once and no done follows.
        wait_idle();
        a = 8'h12; b = 8'h34; a_ns = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0, 0);

        // start held high: new operands each accept, done every N+2 cycles.
        wait_idle();
        a = 8'h3C; b = 8'hC3; a_ns = 1'b0; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            e = model(a, b, a_ns);
            sb.push_back(e);
            @(posedge clk);
            #1;
            a = 8'($urandom); b = 8'($urandom); a_ns = 1'($urandom);
            if (k == 39) start = 1'b0;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while ((busy || done) && cnt < 30);
            chk("b2b_period", 32'(cnt), 32'(N + 2));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
